// File: rtl/mem_bus_master.sv
// mem_bus_master: single-access initiator for the MAIN_MEMORY bus.
// Latches one request, drives address/data, asserts an active-low RD or WR strobe
// until ACK or timeout, then returns read data with a one-cycle DONE pulse.
// Optional macro MEM_MASTER_BUS_ERROR_EN adds a sticky timeout error output.
module mem_bus_master #(
  parameter int unsigned DATAWIDTH_BUS  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4,
  parameter int unsigned TIMER_WIDTH    = 3
) (
  input  logic                     MEM_MASTER_CLOCK_50,
  input  logic                     MEM_MASTER_RESET_InLow,
  input  logic                     MEM_MASTER_REQ_In,
  input  logic                     MEM_MASTER_WE_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_MASTER_ADDR_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEM_MASTER_WDATA_InBUS,
  output logic                     MEM_MASTER_BUSY_Out,
  output logic                     MEM_MASTER_DONE_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_MASTER_RDATA_OutBUS,
  output logic                     MEM_MASTER_MEM_RD_Out,
  output logic                     MEM_MASTER_MEM_WR_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_MASTER_MEM_ADDR_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_MASTER_MEM_DATA_OutBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEM_MASTER_MEM_DATA_InBUS,
  input  logic                     MEM_MASTER_MEM_ACK_In
`ifdef MEM_MASTER_BUS_ERROR_EN
  ,
  output logic                     MEM_MASTER_ERR_Out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_COMPLETE
  } state_e;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
  logic                     we_q, we_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
`ifdef MEM_MASTER_BUS_ERROR_EN
  logic                     err_q, err_d;
`endif

  // State and output registers; strobes return high immediately on reset.
  always_ff @(posedge MEM_MASTER_CLOCK_50 or negedge MEM_MASTER_RESET_InLow) begin
    if (!MEM_MASTER_RESET_InLow) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_MASTER_BUS_ERROR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MEM_MASTER_BUS_ERROR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and next-output logic for the access sequence.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    we_d    = we_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MEM_MASTER_BUS_ERROR_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (MEM_MASTER_REQ_In) begin
          we_d   = MEM_MASTER_WE_In;
          addr_d = MEM_MASTER_ADDR_InBUS;
          if (MEM_MASTER_WE_In) begin
            data_d = MEM_MASTER_WDATA_InBUS;
          end
          busy_d  = 1'b1;
`ifdef MEM_MASTER_BUS_ERROR_EN
          err_d   = 1'b0;
`endif
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        rd_d    = we_q;
        wr_d    = ~we_q;
        timer_d = '0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (MEM_MASTER_MEM_ACK_In) begin
          if (!we_q) begin
            rdata_d = MEM_MASTER_MEM_DATA_InBUS;
          end
          rd_d    = 1'b1;
          wr_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_COMPLETE;
        end else if (timer_q == TIMER_LAST) begin
`ifdef MEM_MASTER_BUS_ERROR_EN
          err_d = 1'b1;
`else
          // Timeout counts as success so memories that never ACK still return data.
          if (!we_q) begin
            rdata_d = MEM_MASTER_MEM_DATA_InBUS;
          end
`endif
          rd_d    = 1'b1;
          wr_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
      S_COMPLETE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign MEM_MASTER_BUSY_Out        = busy_q;
  assign MEM_MASTER_DONE_Out        = done_q;
  assign MEM_MASTER_RDATA_OutBUS    = rdata_q;
  assign MEM_MASTER_MEM_RD_Out      = rd_q;
  assign MEM_MASTER_MEM_WR_Out      = wr_q;
  assign MEM_MASTER_MEM_ADDR_OutBUS = addr_q;
  assign MEM_MASTER_MEM_DATA_OutBUS = data_q;
`ifdef MEM_MASTER_BUS_ERROR_EN
  assign MEM_MASTER_ERR_Out         = err_q;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Testbench for mem_bus_master: access-level reference model checked every cycle,
// plus directed accesses with hand-computed literal expectations.
module tb_mem_bus_master;

  localparam int TO_C = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic        ack   = 1'b0;
  logic        busy, done, rd, wr;
  logic [31:0] rdata, mem_addr, mem_data, mem_din;
`ifdef MEM_MASTER_BUS_ERROR_EN
  logic        err;
`endif

  always #10 clk = ~clk;

  mem_bus_master #(
    .DATAWIDTH_BUS (32),
    .TIMEOUT_CYCLES(4),
    .TIMER_WIDTH   (3)
  ) dut (
    .MEM_MASTER_CLOCK_50       (clk),
    .MEM_MASTER_RESET_InLow    (rst_n),
    .MEM_MASTER_REQ_In         (req),
    .MEM_MASTER_WE_In          (we),
    .MEM_MASTER_ADDR_InBUS     (addr),
    .MEM_MASTER_WDATA_InBUS    (wdata),
    .MEM_MASTER_BUSY_Out       (busy),
    .MEM_MASTER_DONE_Out       (done),
    .MEM_MASTER_RDATA_OutBUS   (rdata),
    .MEM_MASTER_MEM_RD_Out     (rd),
    .MEM_MASTER_MEM_WR_Out     (wr),
    .MEM_MASTER_MEM_ADDR_OutBUS(mem_addr),
    .MEM_MASTER_MEM_DATA_OutBUS(mem_data),
    .MEM_MASTER_MEM_DATA_InBUS (mem_din),
    .MEM_MASTER_MEM_ACK_In     (ack)
`ifdef MEM_MASTER_BUS_ERROR_EN
    ,
    .MEM_MASTER_ERR_Out        (err)
`endif
  );

  // Combinational memory contents.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h800: mem_rd = 32'h82102000;
      32'h804: mem_rd = 32'h84102001;
      32'h808: mem_rd = 32'h86102003;
      32'h80C: mem_rd = 32'h10800004;
      default: mem_rd = 32'h00000000;
    endcase
  endfunction
  assign mem_din = mem_rd(mem_addr);

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ACK responder: asserts ACK once the strobe has been low for ack_delay cycles (-1 = never).
  int ack_delay = -1;
  int low_cnt   = 0;
  always @(negedge clk) begin
    if (!rd || !wr) begin
      ack     <= (ack_delay >= 0) && (low_cnt == ack_delay);
      low_cnt <= low_cnt + 1;
    end else begin
      ack     <= 1'b0;
      low_cnt <= 0;
    end
  end

  // Cycle counter and activity monitor.
  int cyc = 0, rd_low_cnt = 0, wr_low_cnt = 0, done_cnt = 0, done_cyc_last = 0, done_cyc_prev = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rd) rd_low_cnt <= rd_low_cnt + 1;
    if (!wr) wr_low_cnt <= wr_low_cnt + 1;
    if (done) begin
      done_cnt      <= done_cnt + 1;
      done_cyc_prev <= done_cyc_last;
      done_cyc_last <= cyc;
    end
  end

  // Reference model: an access is a timeline of offsets after the accept edge:
  // 1 = address setup, 2..L+1 = strobe low, L+2 = DONE, L+3 = back to idle.
  logic        m_active, m_we, m_to, exp_err;
  int          m_d, m_L;
  logic [31:0] m_rd_val, exp_rdata, exp_addr, exp_data;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_d <= 0; m_L <= 1; m_we <= 1'b0; m_to <= 1'b0; m_rd_val <= '0;
      exp_rdata <= '0; exp_addr <= '0; exp_data <= '0; exp_err <= 1'b0;
    end else if (m_active) begin
      m_d <= m_d + 1;
      if (m_d + 1 == m_L + 2) begin
`ifdef MEM_MASTER_BUS_ERROR_EN
        if (m_to) exp_err <= 1'b1;
        else if (!m_we) exp_rdata <= m_rd_val;
`else
        if (!m_we) exp_rdata <= m_rd_val;
`endif
      end
      if (m_d + 1 == m_L + 3) m_active <= 1'b0;
    end else if (req) begin
      m_active <= 1'b1;
      m_d      <= 1;
      m_we     <= we;
      exp_addr <= addr;
      if (we) exp_data <= wdata;
      m_to     <= !(ack_delay >= 0 && ack_delay < TO_C);
      m_L      <= (ack_delay >= 0 && ack_delay < TO_C) ? ack_delay + 1 : TO_C;
      m_rd_val <= mem_rd(addr);
      exp_err  <= 1'b0;
    end
  end

  function automatic logic in_strobe();
    return m_active && (m_d >= 2) && (m_d <= m_L + 1);
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_active && (m_d == m_L + 2)));
    check("rd_n", 32'(rd), 32'(!(in_strobe() && !m_we)));
    check("wr_n", 32'(wr), 32'(!(in_strobe() && m_we)));
    check("rdata", rdata, exp_rdata);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_data", mem_data, exp_data);
`ifdef MEM_MASTER_BUS_ERROR_EN
    check("err", 32'(err), 32'(exp_err));
`endif
  end

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int dly, output int acc_cyc);
    ack_delay = dly;
    we = w; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt < target) check("done_wait_timeout", 32'(done_cnt), 32'(target));
  endtask

  int a, base_rd, base_wr;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_n", 32'(rd), 32'h1);
    check("reset_wr_n", 32'(wr), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: read 0x800, never ACKed -> 4-cycle strobe then timeout
    base_rd = rd_low_cnt;
    do_access(1'b0, 32'h800, 32'h0, -1, a);
    wait_done(1);
    check("t1_rd_low_cycles", 32'(rd_low_cnt - base_rd), 32'd4);
    check("t1_done_cycle", 32'(done_cyc_last - a), 32'd5);
`ifdef MEM_MASTER_BUS_ERROR_EN
    check("t1_rdata", rdata, 32'h0);
    check("t1_err", 32'(err), 32'h1);
`else
    check("t1_rdata", rdata, 32'h82102000);
`endif
    @(posedge clk); #1;

    // 2: read 0x804, immediate ACK
    base_rd = rd_low_cnt;
    do_access(1'b0, 32'h804, 32'h0, 0, a);
    wait_done(2);
    check("t2_rd_low_cycles", 32'(rd_low_cnt - base_rd), 32'd1);
    check("t2_done_cycle", 32'(done_cyc_last - a), 32'd2);
    check("t2_rdata", rdata, 32'h84102001);
`ifdef MEM_MASTER_BUS_ERROR_EN
    check("t2_err", 32'(err), 32'h0);
`endif
    @(posedge clk); #1;

    // 3: write 0x900 <= 0xDEADBEEF, immediate ACK
    base_rd = rd_low_cnt;
    base_wr = wr_low_cnt;
    do_access(1'b1, 32'h900, 32'hDEADBEEF, 0, a);
    wait_done(3);
    check("t3_wr_low_cycles", 32'(wr_low_cnt - base_wr), 32'd1);
    check("t3_rd_low_cycles", 32'(rd_low_cnt - base_rd), 32'd0);
    check("t3_mem_addr", mem_addr, 32'h900);
    check("t3_mem_data", mem_data, 32'hDEADBEEF);
    check("t3_rdata", rdata, 32'h84102001);
    @(posedge clk); #1;

    // 4: reset asserted while the read strobe is low
    do_access(1'b0, 32'h800, 32'h0, -1, a);
    @(posedge clk); #1;
    check("t4_strobe_low", 32'(rd), 32'h0);
    rst_n = 1'b0;
    #1;
    check("t4_rst_rd_n", 32'(rd), 32'h1);
    check("t4_rst_wr_n", 32'(wr), 32'h1);
    check("t4_rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t4_no_done", 32'(done_cnt), 32'd3);
    do_access(1'b0, 32'h804, 32'h0, 0, a);
    wait_done(4);
    check("t4_rdata_after", rdata, 32'h84102001);
    @(posedge clk); #1;

    // 5: REQ held for two back-to-back reads; REQ toggled while busy
    ack_delay = 0; we = 1'b0; addr = 32'h808; req = 1'b1;
    wait_done(5);
    check("t5_first_rdata", rdata, 32'h86102003);
    addr = 32'h80C;
    @(posedge clk); #1;
    check("t5_second_busy", 32'(busy), 32'h1);
    req = 1'b0;
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done(6);
    repeat (6) @(posedge clk);
    #1;
    check("t5_done_count", 32'(done_cnt), 32'd6);
    check("t5_done_spacing", 32'(done_cyc_last - done_cyc_prev), 32'd4);
    check("t5_second_rdata", rdata, 32'h10800004);

    // 6: read of unmapped address 0x000
    do_access(1'b0, 32'h000, 32'h0, 0, a);
    wait_done(7);
    repeat (4) @(posedge clk);
    #1;
    check("t6_rdata", rdata, 32'h0);
    check("t6_done_count", 32'(done_cnt), 32'd7);
`ifdef MEM_MASTER_BUS_ERROR_EN
    check("t6_err", 32'(err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

endmodule
